// File: rtl/pstretch_pkg.sv
// Shared encodings for the multi-channel pulse stretcher.
// State and mode constants used by the channel FSM and its users.
package pstretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

endpackage

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: rising-edge detect, IDLE/HOLD/COUNT FSM, length counter, sticky ovf.
// Latency: edge sampled at posedge k drives out_pulse high from k; no backpressure, dropped edges flag ovf.
module pulse_stretch_ch
  import pstretch_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_ip,
  input  logic             strch_ip,
  input  logic             mode,
  input  logic [CNT_W-1:0] len_cfg,
  input  logic             retrig_en,
  input  logic             clr_ovf,
  output logic             out_pulse,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_eff;
  logic             event_q;
  logic             ev;
  logic             start;
  logic             ovf_set;

  assign ev      = event_ip & ~event_q;
  assign len_eff = (len_cfg == '0) ? CNT_W'(1) : len_cfg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      event_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_ip;
      // a drop in the same cycle as clr_ovf must stay visible
      if (ovf_set)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: start = ev;
      ST_HOLD: begin
        if (!strch_ip) begin
          state_d = ST_IDLE;
          start   = ev;
        end else begin
          ovf_set = ev;
        end
      end
      ST_COUNT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          start   = ev;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (ev) begin
            if (retrig_en)
              cnt_d = len_eff;
            else
              ovf_set = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // final-cycle edges restart here too, so the output never dips
    if (start) begin
      if (mode == MODE_COUNT) begin
        state_d = ST_COUNT;
        cnt_d   = len_eff;
      end else begin
        state_d = ST_HOLD;
      end
    end
  end

  always_comb begin
    out_pulse = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/multi_pulse_stretcher.sv
// NCH independent pulse stretchers plus an any-channel-active flag.
// Latency: one registered stage per channel; no backpressure, dropped edges flag per-channel ovf.
module multi_pulse_stretcher
  import pstretch_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   event_ip,
  input  logic [NCH-1:0]   strch_ip,
  input  logic [NCH-1:0]   mode,
  input  logic [CNT_W-1:0] len_cfg,
  input  logic             retrig_en,
  input  logic             clr_ovf,
  output logic [NCH-1:0]   out_pulse,
  output logic             out_any,
  output logic [NCH-1:0]   ovf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_stretch_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .event_ip  (event_ip[i]),
      .strch_ip  (strch_ip[i]),
      .mode      (mode[i]),
      .len_cfg   (len_cfg),
      .retrig_en (retrig_en),
      .clr_ovf   (clr_ovf),
      .out_pulse (out_pulse[i]),
      .ovf       (ovf[i])
    );
  end

  assign out_any = |out_pulse;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Directed bench for multi_pulse_stretcher; each stimulus cycle queues its
// hand-derived expected outputs, which are popped and compared after the edge.
module tb_multi_pulse_stretcher;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NCH-1:0]   event_ip = '0;
  logic [NCH-1:0]   strch_ip = '0;
  logic [NCH-1:0]   mode = '0;
  logic [CNT_W-1:0] len_cfg = '0;
  logic             retrig_en = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [NCH-1:0]   out_pulse;
  logic             out_any;
  logic [NCH-1:0]   ovf;

  exp_t  exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string tname  = "rst";

  multi_pulse_stretcher #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .event_ip  (event_ip),
    .strch_ip  (strch_ip),
    .mode      (mode),
    .len_cfg   (len_cfg),
    .retrig_en (retrig_en),
    .clr_ovf   (clr_ovf),
    .out_pulse (out_pulse),
    .out_any   (out_any),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want)
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    else
      n_pass++;
  endtask

  // Drive one cycle, queue what should appear after the edge, then check it.
  task automatic step(input logic [NCH-1:0] ev, input logic [NCH-1:0] st,
                      input logic clr, input logic rst_n,
                      input logic [NCH-1:0] e_out, input logic [NCH-1:0] e_ovf);
    exp_t e;
    event_ip = ev;
    strch_ip = st;
    clr_ovf  = clr;
    reset    = rst_n;
    e.out = e_out;
    e.ovf = e_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tname, ".out"}, 32'(out_pulse), 32'(e.out));
    chk({tname, ".any"}, 32'(out_any),   32'(|e.out));
    chk({tname, ".ovf"}, 32'(ovf),       32'(e.ovf));
  endtask

  initial begin
    // reset state
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);

    // count mode, len 5: exactly five cycles high on ch0 only
    tname = "t1_len5"; mode = 4'hF; len_cfg = 8'd5; retrig_en = 1'b0;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 4; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // len_cfg changed mid-stretch is ignored
    tname = "t1_lenhold"; len_cfg = 8'd3;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    len_cfg = 8'd9;
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // len 0 acts as 1; a held event gives one pulse only
    tname = "t2_len0"; len_cfg = 8'd0;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 9; i++) step(4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // level mode: strch held 3 cycles -> 4 cycles high
    tname = "t3_hold"; mode = 4'h0;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h1, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    tname = "t3_one";
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // level mode: edge while held is dropped and flagged
    tname = "t3_hdrop";
    step(4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h1, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 4'h1);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1);
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0);

    // retrigger 2 cycles in: total width 6, no ovf
    tname = "t4_retrig"; mode = 4'hF; len_cfg = 8'd4; retrig_en = 1'b1;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // no retrigger: width 4, ovf sticky until clr_ovf
    tname = "t4_drop"; retrig_en = 1'b0;
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h1);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1);
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0);

    // edge on final count cycle restarts: 8 cycles continuous, no ovf
    tname = "t5_final";
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // drop and clr_ovf in the same cycle: set wins
    tname = "t5_setwin";
    step(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 4'h0);
    step(4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 4'h1);
    step(4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // mixed modes on all channels at once
    tname = "t_mixed"; mode = 4'b0101; len_cfg = 8'd2;
    step(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    // reset mid-count on every channel, event held through release
    tname = "t6_reset"; mode = 4'hF; len_cfg = 8'd10;
    step(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 4'h0);
    for (int i = 0; i < 9; i++) step(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
